io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Shares the single processor I/O port bus between two requesters: master 0 is the CPU I/O path (driven by the control unit's io read/write enables), master 1 is the debug/program-loader port. The arbiter runs a three-state FSM that grants one transfer at a time with round-robin priority, drives a strobe/ack peripheral bus, and aborts with an error if the peripheral never acknowledges. It sits between the core/loader and the I/O peripheral decode.

## Interface
- ADDR_W, 8, I/O port address width
- DATA_W, 8, I/O data width
- TIMEOUT, 15, BUS-state cycles without ack before abort (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  transfer request, level
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  port address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  valid with done; 1 = timeout abort
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with done, held until next done to that master
- p_stb  out  1  peripheral strobe, high for whole transfer
- p_we  out  1  peripheral write enable
- p_addr  out  ADDR_W  peripheral address
- p_wdata  out  DATA_W  peripheral write data
- p_rdata  in  DATA_W  peripheral read data, sampled on ack
- p_ack  in  1  peripheral acknowledge

## Operation
- States: IDLE, BUS, DONE.
- IDLE: if any req, choose winner, latch its we/addr/wdata into p_we/p_addr/p_wdata, record winner, clear timer, go BUS. Both requesting: grant the master not served last (last_served resets to 1, so m0 wins the first tie). Neither requesting: stay.
- BUS: p_stb = 1. On p_ack: capture p_rdata into winner's rdata (reads only; writes leave rdata unchanged), err = 0, go DONE. No ack: timer++; when timer reaches TIMEOUT go DONE with err = 1, winner's rdata = 0.
- DONE: winner's done = 1 for exactly this cycle, err valid; update last_served; go IDLE.
- Requester holds req and its fields until done, and deasserts req on the cycle after done. Req is sampled only in IDLE, so the DONE→IDLE cycle covers that slack; no double grant.
- p_ack outside BUS is ignored. Ack on the edge where the timer reaches TIMEOUT: ack wins, err = 0.
- Loser's req stays pending untouched and is served next.

## Timing
- Reset values: state IDLE, every output 0 (p_stb, p_we, p_addr, p_wdata, done, err, rdata), timer 0, last_served = 1.
- Latency: req seen in IDLE at edge 0 → p_stb high cycle 1. Ack in cycle 1 → done high cycle 2. Minimum 3-cycle request-to-IDLE turnaround.
- Timeout: p_stb high exactly TIMEOUT cycles, done/err on cycle TIMEOUT+1.
- Back-to-back from both masters: at most one IDLE cycle between transfers. No master starves; the worst-case wait is one foreign transfer.
- Reset mid-transfer: next cycle p_stb = 0, no done/err pulse, in-flight transfer discarded.
- All outputs registered. No combinational path from any input to any output.

## Structure
- Shared package io_arb_pkg: state encoding (IDLE/BUS/DONE as a 2-bit typedef), master index constants M_CPU = 0, M_DBG = 1, default TIMEOUT.
- One sub-module: io_timeout_counter. It is a clear-on-load up-counter with width $clog2(TIMEOUT+1), and asserts `expired` when count == TIMEOUT. It is instantiated once.
- Everything else (FSM, round-robin flag, output registers) lives in io_bus_arbiter.

## Test plan
- Single read, m0, addr 0x12, peripheral acks 2 cycles after p_stb with p_rdata 0xA5 → p_addr = 0x12, p_we = 0, m0_done pulse with m0_rdata = 0xA5, m0_err = 0, m1 outputs untouched.
- Simultaneous m0 write 0x3C@0x01 and m1 read @0x02, immediate acks → m0 served first, then m1. Repeat the tie → m1 served first (alternation).
- No ack, TIMEOUT = 15 → p_stb high exactly 15 cycles, m1_done with m1_err = 1, m1_rdata = 0x00. The next request proceeds normally.
- Ack arrives on the TIMEOUT-th BUS cycle → err = 0, data captured. Stray p_ack in IDLE → no done, no state change.
- Reset asserted while in BUS → p_stb low next cycle, no done. After reset release, a tie grants m0.
- Continuous m0 req with m1 req → m1 is granted no later than the second transfer (no starvation), with a single IDLE cycle between transfers.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the I/O port bus arbiter: FSM state encoding,
// master indices and the default acknowledge timeout.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/io_bus_arbiter_timeout_counter.sv
// Clear-on-load up-counter that watches how long a bus transfer has waited
// for its acknowledge.
module io_timeout_counter
  import io_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count != CW'(TIMEOUT))) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Flags the edge on which the count reaches TIMEOUT, so the owner can leave
  // its wait state on that same edge.
  assign expired = (count_next == CW'(TIMEOUT));

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the I/O port bus between the CPU I/O path (m0)
// and the debug/program-loader port (m1), with an ack timeout abort.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              p_stb,
  output logic              p_we,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_ack
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  arb_state_t state;
  arb_state_t next_state;

  logic winner;
  logic last_served;
  logic grant_sel;
  logic load;
  logic stb_d;
  logic done_d;
  logic err_d;
  logic timer_clear;
  logic timer_inc;
  logic timer_expired;

  io_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (TCW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (m0_req || m1_req) next_state = BUS;
      BUS:     if (p_ack || timer_expired) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On a tie the master that was not served last wins; a lone requester
  // always wins.
  always_comb begin
    grant_sel   = (m0_req && m1_req) ? ~last_served : m1_req;
    load        = (state == IDLE) && (next_state == BUS);
    stb_d       = (next_state == BUS);
    done_d      = (state == BUS) && (next_state == DONE);
    err_d       = done_d && !p_ack;
    timer_clear = (state == IDLE);
    timer_inc   = (state == BUS) && !p_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_stb       <= 1'b0;
      p_we        <= 1'b0;
      p_addr      <= '0;
      p_wdata     <= '0;
      winner      <= M_CPU;
      last_served <= M_DBG;
      m0_done     <= 1'b0;
      m1_done     <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      p_stb   <= stb_d;
      m0_done <= done_d && (winner == M_CPU);
      m1_done <= done_d && (winner == M_DBG);
      m0_err  <= err_d && (winner == M_CPU);
      m1_err  <= err_d && (winner == M_DBG);

      if (load) begin
        winner  <= grant_sel;
        p_we    <= grant_sel ? m1_we    : m0_we;
        p_addr  <= grant_sel ? m1_addr  : m0_addr;
        p_wdata <= grant_sel ? m1_wdata : m0_wdata;
      end

      // A timeout zeroes the winner's read data; an acked write leaves it alone.
      if (done_d && (winner == M_CPU)) begin
        if (!p_ack) begin
          m0_rdata <= '0;
        end else if (!p_we) begin
          m0_rdata <= p_rdata;
        end
      end
      if (done_d && (winner == M_DBG)) begin
        if (!p_ack) begin
          m1_rdata <= '0;
        end else if (!p_we) begin
          m1_rdata <= p_rdata;
        end
      end

      if (state == DONE) begin
        last_served <= winner;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed vector tables, hand-written
// timeout/reset sequences and a randomized run against a transaction model.
module tb_io_bus_arbiter;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_done, m0_err;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_done, m1_err;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              p_stb, p_we, p_ack;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata, p_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_done  (m0_done),
    .m0_err   (m0_err),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_done  (m1_done),
    .m1_err   (m1_err),
    .m1_rdata (m1_rdata),
    .p_stb    (p_stb),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_ack    (p_ack)
  );

  typedef struct {
    logic       rst, r0, r1, ack;
    logic [7:0] prd;
    logic       stb, d0, d1, err;
    logic [7:0] rd0, rd1, addr;
    logic       we;
    logic [7:0] wd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic r0, logic r1, logic ack, logic [7:0] prd,
                              logic stb, logic d0, logic d1, logic err,
                              logic [7:0] rd0, logic [7:0] rd1, logic [7:0] addr,
                              logic we, logic [7:0] wd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.ack = ack; v.prd = prd;
    v.stb = stb; v.d0 = d0; v.d1 = d1; v.err = err;
    v.rd0 = rd0; v.rd1 = rd1; v.addr = addr; v.we = we; v.wd = wd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset   = v.rst;
    m0_req  = v.r0;
    m1_req  = v.r1;
    p_ack   = v.ack;
    p_rdata = v.prd;
    tick();
  endtask

  task automatic checkVector(input string tag, input int i, input vec_t v);
    checkOutput($sformatf("%s[%0d].stb", tag, i), p_stb, v.stb);
    checkOutput($sformatf("%s[%0d].m0_done", tag, i), m0_done, v.d0);
    checkOutput($sformatf("%s[%0d].m1_done", tag, i), m1_done, v.d1);
    checkOutput($sformatf("%s[%0d].m0_rdata", tag, i), m0_rdata, v.rd0);
    checkOutput($sformatf("%s[%0d].m1_rdata", tag, i), m1_rdata, v.rd1);
    if (v.d0) checkOutput($sformatf("%s[%0d].m0_err", tag, i), m0_err, v.err);
    if (v.d1) checkOutput($sformatf("%s[%0d].m1_err", tag, i), m1_err, v.err);
    if (v.stb) begin
      checkOutput($sformatf("%s[%0d].p_addr", tag, i), p_addr, v.addr);
      checkOutput($sformatf("%s[%0d].p_we", tag, i), p_we, v.we);
      checkOutput($sformatf("%s[%0d].p_wdata", tag, i), p_wdata, v.wd);
    end
  endtask

  vec_t rd_tab[$];
  vec_t tie_tab[$];

  // Transaction-level reference state for the randomized run.
  bit         pend0, pend1, drop0, drop1, seen0, seen1;
  bit         m_in, m_done, m_win, m_last, m_err, e_we;
  int         m_cnt, m_ack_at;
  logic [7:0] m_rd0, m_rd1, e_addr, e_wd;

  initial begin
    int  stb_cycles;
    bit  got;

    reset = 1'b1; m0_req = 0; m1_req = 0; p_ack = 0; p_rdata = '0;
    m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_we = 0; m1_addr = '0; m1_wdata = '0;

    tick();
    tick();
    checkOutput("rst.p_stb", p_stb, 0);
    checkOutput("rst.p_we", p_we, 0);
    checkOutput("rst.p_addr", p_addr, 0);
    checkOutput("rst.p_wdata", p_wdata, 0);
    checkOutput("rst.m0_done", m0_done, 0);
    checkOutput("rst.m1_done", m1_done, 0);
    checkOutput("rst.m0_err", m0_err, 0);
    checkOutput("rst.m1_err", m1_err, 0);
    checkOutput("rst.m0_rdata", m0_rdata, 0);
    checkOutput("rst.m1_rdata", m1_rdata, 0);

    // m0 single read of 0x12, acked in the third strobe cycle, then a stray ack.
    rd_tab.push_back(mk(1,0,0,0,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00,0,8'h00));
    rd_tab.push_back(mk(0,1,0,0,8'h00, 1,0,0,0, 8'h00,8'h00,8'h12,0,8'h99));
    rd_tab.push_back(mk(0,1,0,0,8'h00, 1,0,0,0, 8'h00,8'h00,8'h12,0,8'h99));
    rd_tab.push_back(mk(0,1,0,0,8'h00, 1,0,0,0, 8'h00,8'h00,8'h12,0,8'h99));
    rd_tab.push_back(mk(0,1,0,1,8'hA5, 0,1,0,0, 8'hA5,8'h00,8'h00,0,8'h00));
    rd_tab.push_back(mk(0,1,0,0,8'h00, 0,0,0,0, 8'hA5,8'h00,8'h00,0,8'h00));
    rd_tab.push_back(mk(0,0,0,1,8'hFF, 0,0,0,0, 8'hA5,8'h00,8'h00,0,8'h00));
    rd_tab.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 8'hA5,8'h00,8'h00,0,8'h00));

    m0_we = 0; m0_addr = 8'h12; m0_wdata = 8'h99;
    m1_we = 0; m1_addr = 8'h34; m1_wdata = 8'h00;
    foreach (rd_tab[i]) begin
      applyStimulus(rd_tab[i]);
      checkVector("read", i, rd_tab[i]);
    end

    // Ties: m0 write 0x3C@0x01 against m1 read @0x02, with immediate acks.
    tie_tab.push_back(mk(1,0,0,0,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,1,0,8'h00, 1,0,0,0, 8'h00,8'h00,8'h01,1,8'h3C));
    tie_tab.push_back(mk(0,1,1,1,8'h77, 0,1,0,0, 8'h00,8'h00,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,1,0,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,0,1,0,8'h00, 1,0,0,0, 8'h00,8'h00,8'h02,0,8'h5B));
    tie_tab.push_back(mk(0,0,1,1,8'h5A, 0,0,1,0, 8'h00,8'h5A,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,0,1,0,8'h00, 0,0,0,0, 8'h00,8'h5A,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,0,0,8'h00, 1,0,0,0, 8'h00,8'h5A,8'h01,1,8'h3C));
    tie_tab.push_back(mk(0,1,0,1,8'h11, 0,1,0,0, 8'h00,8'h5A,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,0,0,8'h00, 0,0,0,0, 8'h00,8'h5A,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 8'h00,8'h5A,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,1,0,8'h00, 1,0,0,0, 8'h00,8'h5A,8'h02,0,8'h5B));
    tie_tab.push_back(mk(0,1,1,1,8'hC3, 0,0,1,0, 8'h00,8'hC3,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,1,0,8'h00, 0,0,0,0, 8'h00,8'hC3,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,0,0,8'h00, 1,0,0,0, 8'h00,8'hC3,8'h01,1,8'h3C));
    tie_tab.push_back(mk(0,1,0,1,8'h22, 0,1,0,0, 8'h00,8'hC3,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,1,0,0,8'h00, 0,0,0,0, 8'h00,8'hC3,8'h00,0,8'h00));
    tie_tab.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 8'h00,8'hC3,8'h00,0,8'h00));

    m0_we = 1; m0_addr = 8'h01; m0_wdata = 8'h3C;
    m1_we = 0; m1_addr = 8'h02; m1_wdata = 8'h5B;
    foreach (tie_tab[i]) begin
      applyStimulus(tie_tab[i]);
      checkVector("tie", i, tie_tab[i]);
    end

    // No ack at all: strobe must last exactly TIMEOUT cycles, then err.
    m1_we = 0; m1_addr = 8'h04; m1_req = 1; p_ack = 0;
    stb_cycles = 0; got = 0;
    for (int i = 0; i < 3 * TIMEOUT && !got; i++) begin
      tick();
      if (p_stb) stb_cycles++;
      if (m0_done) checkOutput("to.no_m0_done", m0_done, 0);
      if (m1_done) begin
        got = 1;
        checkOutput("to.m1_err", m1_err, 1);
        checkOutput("to.m1_rdata", m1_rdata, 8'h00);
      end
    end
    checkOutput("to.done_seen", got, 1);
    checkOutput("to.stb_cycles", stb_cycles, TIMEOUT);
    tick();
    m1_req = 0;
    tick();

    // Ack on the last permitted strobe cycle: ack wins over the timeout.
    m1_addr = 8'h06; m1_req = 1;
    tick();
    checkOutput("late.stb_first", p_stb, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checkOutput("late.stb_last", p_stb, 1);
    checkOutput("late.no_early_done", m1_done, 0);
    p_ack = 1; p_rdata = 8'h6E;
    tick();
    p_ack = 0;
    checkOutput("late.m1_done", m1_done, 1);
    checkOutput("late.m1_err", m1_err, 0);
    checkOutput("late.m1_rdata", m1_rdata, 8'h6E);
    tick();
    m1_req = 0;
    tick();

    // Reset while the bus is busy discards the transfer; a tie then goes to m0.
    m0_we = 0; m0_addr = 8'h08; m0_req = 1;
    tick();
    tick();
    checkOutput("mid.stb_before", p_stb, 1);
    reset = 1; p_ack = 1; p_rdata = 8'hAA;
    tick();
    checkOutput("mid.stb", p_stb, 0);
    checkOutput("mid.m0_done", m0_done, 0);
    checkOutput("mid.m0_err", m0_err, 0);
    checkOutput("mid.m0_rdata", m0_rdata, 0);
    reset = 0; p_ack = 0; m1_we = 0; m1_addr = 8'h0A; m1_req = 1;
    tick();
    checkOutput("mid.tie_stb", p_stb, 1);
    checkOutput("mid.tie_addr", p_addr, 8'h08);
    p_ack = 1; p_rdata = 8'h42;
    tick();
    p_ack = 0;
    checkOutput("mid.m0_done2", m0_done, 1);
    checkOutput("mid.m0_rdata2", m0_rdata, 8'h42);
    checkOutput("mid.m1_idle", m1_done, 0);
    tick();
    m0_req = 0;
    tick();
    checkOutput("mid.m1_stb", p_stb, 1);
    checkOutput("mid.m1_addr", p_addr, 8'h0A);
    p_ack = 1; p_rdata = 8'h24;
    tick();
    p_ack = 0;
    checkOutput("mid.m1_done", m1_done, 1);
    checkOutput("mid.m1_rdata", m1_rdata, 8'h24);
    tick();
    m1_req = 0;

    // Randomized masters and peripheral against the transaction model.
    reset = 1;
    tick();
    reset = 0;
    pend0 = 0; pend1 = 0; drop0 = 0; drop1 = 0; seen0 = 0; seen1 = 0;
    m_in = 0; m_done = 0; m_win = 0; m_last = 1; m_err = 0; e_we = 0;
    m_cnt = 0; m_ack_at = 0; m_rd0 = 0; m_rd1 = 0; e_addr = 0; e_wd = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (seen0) drop0 = 1;
      else if (drop0) begin pend0 = 0; drop0 = 0; end
      else if (!pend0 && $urandom_range(0, 3) == 0) begin
        pend0 = 1;
        m0_we = 1'($urandom_range(0, 1));
        m0_addr = 8'($urandom) & 8'hFE;
        m0_wdata = 8'($urandom);
      end
      if (seen1) drop1 = 1;
      else if (drop1) begin pend1 = 0; drop1 = 0; end
      else if (!pend1 && $urandom_range(0, 3) == 0) begin
        pend1 = 1;
        m1_we = 1'($urandom_range(0, 1));
        m1_addr = 8'($urandom) | 8'h01;
        m1_wdata = 8'($urandom);
      end
      m0_req = pend0;
      m1_req = pend1;
      p_ack = m_in ? (m_cnt == m_ack_at) : ($urandom_range(0, 7) == 0);
      p_rdata = 8'($urandom);

      if (m_done) begin
        m_done = 0;
        m_last = m_win;
      end else if (m_in) begin
        if (p_ack || m_cnt == TIMEOUT) begin
          m_in = 0;
          m_done = 1;
          m_err = !p_ack;
          if (!p_ack) begin
            if (m_win) m_rd1 = 8'h00; else m_rd0 = 8'h00;
          end else if (!e_we) begin
            if (m_win) m_rd1 = p_rdata; else m_rd0 = p_rdata;
          end
        end else begin
          m_cnt++;
        end
      end else if (m0_req || m1_req) begin
        m_win = (m0_req && m1_req) ? !m_last : m1_req;
        m_in = 1;
        m_cnt = 1;
        m_ack_at = $urandom_range(1, TIMEOUT + 3);
        e_addr = m_win ? m1_addr : m0_addr;
        e_we = m_win ? m1_we : m0_we;
        e_wd = m_win ? m1_wdata : m0_wdata;
      end

      tick();
      checkOutput($sformatf("rnd[%0d].stb", cyc), p_stb, m_in);
      checkOutput($sformatf("rnd[%0d].m0_done", cyc), m0_done, m_done && !m_win);
      checkOutput($sformatf("rnd[%0d].m1_done", cyc), m1_done, m_done && m_win);
      checkOutput($sformatf("rnd[%0d].m0_rdata", cyc), m0_rdata, m_rd0);
      checkOutput($sformatf("rnd[%0d].m1_rdata", cyc), m1_rdata, m_rd1);
      if (m_done && !m_win) checkOutput($sformatf("rnd[%0d].m0_err", cyc), m0_err, m_err);
      if (m_done && m_win) checkOutput($sformatf("rnd[%0d].m1_err", cyc), m1_err, m_err);
      if (m_in) begin
        checkOutput($sformatf("rnd[%0d].p_addr", cyc), p_addr, e_addr);
        checkOutput($sformatf("rnd[%0d].p_we", cyc), p_we, e_we);
        checkOutput($sformatf("rnd[%0d].p_wdata", cyc), p_wdata, e_wd);
      end
      seen0 = m_done && !m_win;
      seen1 = m_done && m_win;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
